// File: rtl/deserializer.sv
// Serial-to-parallel receiver: packs an MSB-first bit stream into DATA_W-bit words,
// pulsing each full word or left-justified partial tail for one cycle.
module deserializer #(
  parameter int DATA_W     = 16,
  parameter int DATA_MOD_W = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  ser_data_i,
  input  logic                  ser_data_val_i,
  output logic [DATA_W-1:0]     deser_data_o,
  output logic [DATA_MOD_W-1:0] deser_data_mod_o,
  output logic                  deser_data_val_o
);

  localparam int CNT_W = DATA_MOD_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [DATA_W-1:0]     shifted_in;
  logic [DATA_W-1:0]     flush_word;
  logic [CNT_W-1:0]      flush_amt;
  logic [DATA_W-1:0]     data_d;
  logic [DATA_MOD_W-1:0] mod_d;
  logic                  val_d;

  always_comb begin
    shifted_in = {shift_q[DATA_W-2:0], ser_data_i};
    flush_amt  = FULL_CNT - cnt_q;
    // Partial bits sit right-aligned in the shift register; move them to the top.
    flush_word = shift_q << flush_amt;

    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = deser_data_o;
    mod_d   = deser_data_mod_o;
    val_d   = 1'b0;

    if (ser_data_val_i) begin
      if (cnt_q == LAST_CNT) begin
        data_d  = shifted_in;
        mod_d   = '0;
        val_d   = 1'b1;
        cnt_d   = '0;
        shift_d = '0;
      end else begin
        shift_d = shifted_in;
        cnt_d   = cnt_q + ONE_CNT;
      end
    end else if (cnt_q != '0) begin
      data_d  = flush_word;
      mod_d   = cnt_q[DATA_MOD_W-1:0];
      val_d   = 1'b1;
      cnt_d   = '0;
      shift_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q            <= '0;
      shift_q          <= '0;
      deser_data_o     <= '0;
      deser_data_mod_o <= '0;
      deser_data_val_o <= 1'b0;
    end else begin
      cnt_q            <= cnt_d;
      shift_q          <= shift_d;
      deser_data_o     <= data_d;
      deser_data_mod_o <= mod_d;
      deser_data_val_o <= val_d;
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: a bit-level model queues expected words with
// their expected output cycle; a monitor pops and compares each pulse.
module tb_deserializer;

  localparam int DATA_W     = 16;
  localparam int DATA_MOD_W = 4;

  typedef struct {
    logic [DATA_W-1:0]     data;
    logic [DATA_MOD_W-1:0] mod;
    int                    cyc;
  } exp_t;

  logic                  clk_i = 1'b0;
  logic                  arst_n_i;
  logic                  ser_data_i;
  logic                  ser_data_val_i;
  logic [DATA_W-1:0]     deser_data_o;
  logic [DATA_MOD_W-1:0] deser_data_mod_o;
  logic                  deser_data_val_o;

  exp_t              sb[$];
  int                cycle_cnt = 0;
  int                num_checks = 0;
  int                num_errors = 0;
  int                model_n = 0;
  logic [DATA_W-1:0] model_word = '0;
  logic [DATA_W-1:0] last_data = '0;

  deserializer #(.DATA_W(DATA_W), .DATA_MOD_W(DATA_MOD_W)) dut (
    .clk_i            (clk_i),
    .arst_n_i         (arst_n_i),
    .ser_data_i       (ser_data_i),
    .ser_data_val_i   (ser_data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_data_mod_o (deser_data_mod_o),
    .deser_data_val_o (deser_data_val_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle_cnt);
    end
  endtask

  task automatic push_expected(input logic [DATA_W-1:0] data, input int n);
    exp_t e;
    e.data = data;
    e.mod  = DATA_MOD_W'(n % DATA_W);
    e.cyc  = cycle_cnt + 1;
    sb.push_back(e);
    last_data  = data;
    model_word = '0;
    model_n    = 0;
  endtask

  // Model places each bit directly at its final left-justified position.
  task automatic applyStimulus(input logic val, input logic bit_v);
    ser_data_val_i = val;
    ser_data_i     = bit_v;
    if (val) begin
      model_word[DATA_W-1-model_n] = bit_v;
      model_n++;
      if (model_n == DATA_W) push_expected(model_word, DATA_W);
    end else if (model_n > 0) begin
      push_expected(model_word, model_n);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, v[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  always @(negedge clk_i) begin
    if (arst_n_i) begin
      if (deser_data_val_o) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_pulse", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("pulse_cycle", cycle_cnt, e.cyc);
          checkOutput("data", 32'(deser_data_o), 32'(e.data));
          checkOutput("mod", 32'(deser_data_mod_o), 32'(e.mod));
        end
      end else if (sb.size() != 0 && sb[0].cyc < cycle_cnt) begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("missing_pulse", 32'(deser_data_val_o), 32'd1);
      end
    end
  end

  initial begin
    arst_n_i       = 1'b0;
    ser_data_i     = 1'b0;
    ser_data_val_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_data", 32'(deser_data_o), 32'd0);
    checkOutput("reset_mod", 32'(deser_data_mod_o), 32'd0);
    checkOutput("reset_val", 32'(deser_data_val_o), 32'd0);
    arst_n_i = 1'b1;
    idle(2);

    send_bits(32'hA5C3, 16);
    idle(3);
    checkOutput("hold_data", 32'(deser_data_o), 32'(last_data));
    checkOutput("hold_val", 32'(deser_data_val_o), 32'd0);

    send_bits(32'b10110, 5);
    idle(2);

    send_bits(32'h1234_ABCD, 32);
    idle(2);

    send_bits(32'hF_FFFF, 20);
    idle(2);

    send_bits(32'b1, 1);
    idle(1);
    send_bits(32'b01, 2);
    idle(3);

    // Abort a frame with reset; the seven buffered bits must vanish.
    send_bits(32'b1010101, 7);
    arst_n_i   = 1'b0;
    model_word = '0;
    model_n    = 0;
    #1;
    checkOutput("midreset_data", 32'(deser_data_o), 32'd0);
    checkOutput("midreset_mod", 32'(deser_data_mod_o), 32'd0);
    checkOutput("midreset_val", 32'(deser_data_val_o), 32'd0);
    ser_data_val_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    arst_n_i = 1'b1;
    idle(1);
    send_bits(32'h0F0F, 16);
    idle(4);

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
